// File: rtl/sram_responder.sv
// SRAM-style memory responder: word-organised data RAM with byte enables plus a
// small MMIO block (LED, free-running timer, scratch, ID). Reads have 1-cycle latency.
module sram_responder #(
  parameter int          ADDR_W    = 12,
  parameter logic [31:0] MMIO_BASE = 32'hBFAF_0000,
  parameter logic [31:0] ID_VALUE  = 32'h1C0A_0012
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sram_en,
  input  logic [3:0]  sram_we,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  output logic [15:0] led,
  output logic [31:0] timer
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [13:0] OFF_LED     = 14'h0;
  localparam logic [13:0] OFF_TIMER   = 14'h1;
  localparam logic [13:0] OFF_SCRATCH = 14'h2;
  localparam logic [13:0] OFF_ID      = 14'h3;

  logic [31:0]       mem [DEPTH];
  logic [31:0]       scratch;
  logic              mmio_hit;
  logic [ADDR_W-1:0] ram_idx;
  logic [13:0]       mmio_word;
  logic [31:0]       wmask;
  logic [31:0]       mmio_rdata;
  logic              mmio_write;
  logic              ram_write;
  logic              unused_addr_bits;

  assign mmio_hit         = (sram_addr[31:16] == MMIO_BASE[31:16]);
  assign ram_idx          = sram_addr[ADDR_W+1:2];
  assign mmio_word        = sram_addr[15:2];
  assign wmask            = {{8{sram_we[3]}}, {8{sram_we[2]}}, {8{sram_we[1]}}, {8{sram_we[0]}}};
  assign mmio_write       = sram_en && mmio_hit && (sram_we != 4'h0);
  assign ram_write        = sram_en && !mmio_hit && !reset;
  assign unused_addr_bits = ^sram_addr[1:0];

  function automatic logic [31:0] merge(input logic [31:0] old_val, input logic [31:0] new_val,
                                        input logic [31:0] mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

  always_comb begin
    mmio_rdata = 32'h0;
    case (mmio_word)
      OFF_LED:     mmio_rdata = {16'h0, led};
      OFF_TIMER:   mmio_rdata = timer;
      OFF_SCRATCH: mmio_rdata = scratch;
      OFF_ID:      mmio_rdata = ID_VALUE;
      default:     mmio_rdata = 32'h0;
    endcase
  end

  // Read-first: the registered read value always captures the pre-edge contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sram_rdata <= 32'h0;
    end else if (sram_en) begin
      sram_rdata <= mmio_hit ? mmio_rdata : mem[ram_idx];
    end
  end

  // RAM is deliberately left out of reset so its contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (ram_write) begin
      for (int i = 0; i < 4; i++) begin
        if (sram_we[i]) begin
          mem[ram_idx][8*i +: 8] <= sram_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led     <= 16'h0;
      scratch <= 32'h0;
    end else if (mmio_write) begin
      if (mmio_word == OFF_LED) begin
        led <= merge({16'h0, led}, sram_wdata, wmask) & 32'h0000_FFFF;
      end
      if (mmio_word == OFF_SCRATCH) begin
        scratch <= merge(scratch, sram_wdata, wmask);
      end
    end
  end

  // A timer write loads the merged value and takes the place of that edge's increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer <= 32'h0;
    end else if (mmio_write && (mmio_word == OFF_TIMER)) begin
      timer <= merge(timer, sram_wdata, wmask);
    end else begin
      timer <= timer + 32'h1;
    end
  end

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_sram_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sram_en = 1'b0;
  logic [3:0]  sram_we = 4'h0;
  logic [31:0] sram_addr = 32'h0;
  logic [31:0] sram_wdata = 32'h0;
  logic [31:0] sram_rdata;
  logic [15:0] led;
  logic [31:0] timer;

  int checks = 0;
  int errors = 0;

  sram_responder dut (
    .clk        (clk),
    .reset      (reset),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .led        (led),
    .timer      (timer)
  );

  always #5 clk = ~clk;

  // Model state: timer is held as "value loaded at some edge" plus edges elapsed since.
  logic [31:0] m_ram [4096];
  bit          m_valid [4096];
  logic [15:0] m_led = 16'h0;
  logic [31:0] m_scratch = 32'h0;
  logic [31:0] m_rdata = 32'h0;
  bit          m_known = 1'b1;
  logic [31:0] t_base = 32'h0;
  int unsigned edges = 0;
  int unsigned t_load = 0;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_val, input logic [31:0] wd,
                                             input logic [3:0] we);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (we[i]) res[8*i +: 8] = wd[8*i +: 8];
    end
    return res;
  endfunction

  function automatic logic [31:0] model_timer();
    return t_base + (edges - t_load);
  endfunction

  always @(posedge clk or posedge reset) begin
    logic [31:0] cur;
    logic [31:0] old_val;
    logic [31:0] merged;
    int          idx;
    if (reset) begin
      m_rdata   = 32'h0;
      m_known   = 1'b1;
      m_led     = 16'h0;
      m_scratch = 32'h0;
      t_base    = 32'h0;
      t_load    = edges;
    end else begin
      cur = model_timer();
      edges++;
      if (sram_en) begin
        if (sram_addr[31:16] == 16'hBFAF) begin
          case (sram_addr[15:0])
            16'h0:   old_val = {16'h0, m_led};
            16'h4:   old_val = cur;
            16'h8:   old_val = m_scratch;
            16'hC:   old_val = 32'h1C0A_0012;
            default: old_val = 32'h0;
          endcase
          m_rdata = old_val;
          m_known = 1'b1;
          if (sram_we != 4'h0) begin
            merged = lane_merge(old_val, sram_wdata, sram_we);
            case (sram_addr[15:0])
              16'h0: m_led = merged[15:0];
              16'h4: begin t_base = merged; t_load = edges; end
              16'h8: m_scratch = merged;
              default: ;
            endcase
          end
        end else begin
          idx     = int'(sram_addr[13:2]);
          m_rdata = m_ram[idx];
          m_known = m_valid[idx];
          if (sram_we != 4'h0) begin
            m_ram[idx] = lane_merge(m_ram[idx], sram_wdata, sram_we);
            if (sram_we == 4'hF) m_valid[idx] = 1'b1;
          end
        end
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_known) check_output("model_rdata", sram_rdata, m_rdata);
    check_output("model_led", {16'h0, led}, {16'h0, m_led});
    check_output("model_timer", timer, model_timer());
  end

  // Drives one cycle's request from a point away from the edge, then settles just after it.
  task automatic apply_stimulus(input logic en, input logic [3:0] we, input logic [31:0] addr,
                                input logic [31:0] wdata);
    sram_en    = en;
    sram_we    = we;
    sram_addr  = addr;
    sram_wdata = wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    apply_stimulus(1'b0, 4'($urandom), $urandom, $urandom);
  endtask

  initial begin
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;

    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("reset_rdata", sram_rdata, 32'h0);
    check_output("reset_timer", timer, 32'h0);
    reset = 1'b0;
    #1;

    repeat (10) idle_cycle();
    check_output("timer_after_10", timer, 32'd10);
    check_output("rdata_before_access", sram_rdata, 32'h0);

    apply_stimulus(1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF);
    apply_stimulus(1'b1, 4'h0, 32'h0000_0010, 32'h0);
    check_output("read_0x10", sram_rdata, 32'hDEAD_BEEF);

    apply_stimulus(1'b1, 4'hF, 32'h0000_0020, 32'h1122_3344);
    apply_stimulus(1'b1, 4'b0101, 32'h0000_0020, 32'hAABB_CCDD);
    check_output("read_first_write", sram_rdata, 32'h1122_3344);
    apply_stimulus(1'b1, 4'h0, 32'h0000_0020, 32'h0);
    check_output("byte_merge", sram_rdata, 32'h11BB_33DD);

    apply_stimulus(1'b1, 4'hF, 32'h0000_4000, 32'h0000_0005);
    apply_stimulus(1'b1, 4'h0, 32'h0000_0000, 32'h0);
    check_output("alias_0x0", sram_rdata, 32'h0000_0005);
    apply_stimulus(1'b1, 4'h0, 32'h0000_4003, 32'h0);
    check_output("alias_low_bits", sram_rdata, 32'h0000_0005);

    apply_stimulus(1'b1, 4'hF, 32'hBFAF_0000, 32'hFFFF_1234);
    check_output("led_port", {16'h0, led}, 32'h0000_1234);
    apply_stimulus(1'b1, 4'h0, 32'hBFAF_0000, 32'h0);
    check_output("led_readback", sram_rdata, 32'h0000_1234);
    apply_stimulus(1'b1, 4'h0, 32'hBFAF_000C, 32'h0);
    check_output("id_read", sram_rdata, 32'h1C0A_0012);
    apply_stimulus(1'b1, 4'hF, 32'hBFAF_000C, 32'h0000_0000);
    apply_stimulus(1'b1, 4'h0, 32'hBFAF_000C, 32'h0);
    check_output("id_readonly", sram_rdata, 32'h1C0A_0012);
    apply_stimulus(1'b1, 4'h0, 32'hBFAF_0010, 32'h0);
    check_output("unmapped_read", sram_rdata, 32'h0);

    apply_stimulus(1'b1, 4'hF, 32'hBFAF_0004, 32'hFFFF_FFFE);
    check_output("timer_load", timer, 32'hFFFF_FFFE);
    idle_cycle();
    check_output("timer_inc", timer, 32'hFFFF_FFFF);
    idle_cycle();
    check_output("timer_wrap", timer, 32'h0);

    for (int w = 64; w < 128; w++) begin
      apply_stimulus(1'b1, 4'hF, 32'(w) << 2, $urandom);
    end

    for (int n = 0; n < 1500; n++) begin
      en = ($urandom_range(0, 9) < 8);
      if (!en) begin
        we   = 4'($urandom);
        addr = $urandom;
      end else begin
        we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
        if ($urandom_range(0, 3) == 0) begin
          addr = {16'hBFAF, 16'(4 * $urandom_range(0, 5))};
        end else begin
          addr = (32'($urandom_range(0, 255)) << 14) | (32'($urandom_range(64, 127)) << 2)
               | 32'($urandom_range(0, 3));
        end
      end
      apply_stimulus(en, we, addr, $urandom);
    end

    apply_stimulus(1'b1, 4'hF, 32'hBFAF_0000, 32'h0000_ABCD);
    apply_stimulus(1'b1, 4'h0, 32'h0000_0010, 32'h0);
    apply_stimulus(1'b1, 4'h0, 32'h0000_0010, 32'h0);
    check_output("pre_reset_read", sram_rdata, 32'hDEAD_BEEF);
    #2 reset = 1'b1;
    #1;
    check_output("async_rdata", sram_rdata, 32'h0);
    check_output("async_led", {16'h0, led}, 32'h0);
    check_output("async_timer", timer, 32'h0);
    sram_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    idle_cycle();
    check_output("rdata_held_after_reset", sram_rdata, 32'h0);
    apply_stimulus(1'b1, 4'h0, 32'h0000_0010, 32'h0);
    check_output("ram_retained", sram_rdata, 32'hDEAD_BEEF);
    idle_cycle();

    $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
